// File: rtl/mcu_block_sequencer_pkg.sv
// Shared encodings for the MCU block sequencer: FSM states, sampling modes,
// component codes, and the mode-dependent block layout of one MCU.
package mcu_block_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SM_444  = 2'd0,
    SM_422  = 2'd1,
    SM_420  = 2'd2,
    SM_GRAY = 2'd3
  } samp_mode_e;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  function automatic logic [2:0] blocks_per_mcu(input samp_mode_e m);
    logic [2:0] n;
    n = 3'd1;
    case (m)
      SM_444:  n = 3'd3;
      SM_422:  n = 3'd4;
      SM_420:  n = 3'd6;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

  // Luma blocks come first in every mode, followed by one Cb and one Cr.
  function automatic comp_e blk_comp(input samp_mode_e m, input logic [2:0] blk);
    comp_e c;
    c = COMP_Y;
    case (m)
      SM_444:  c = (blk == 3'd0) ? COMP_Y : (blk == 3'd1) ? COMP_CB : COMP_CR;
      SM_422:  c = (blk < 3'd2) ? COMP_Y : (blk == 3'd2) ? COMP_CB : COMP_CR;
      SM_420:  c = (blk < 3'd4) ? COMP_Y : (blk == 3'd4) ? COMP_CB : COMP_CR;
      default: c = COMP_Y;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mcu_block_sequencer_if.sv
// Coefficient streams around the sequencer: expander side (i_de/i_B/o_shift_ready)
// and downstream side (i_ready, registered o_* coefficient outputs).
interface mcu_block_sequencer_if #(
  parameter int AMPLITUDE_PRECISION = 16
) ();
  logic                           i_de;
  logic [AMPLITUDE_PRECISION-1:0] i_B;
  logic                           o_shift_ready;
  logic                           i_ready;
  logic                           o_de;
  logic [AMPLITUDE_PRECISION-1:0] o_B;
  logic [5:0]                     o_coef_idx;
  logic [2:0]                     o_blk_idx;
  logic [1:0]                     o_comp;

  modport master (
    output i_de, i_B, i_ready,
    input  o_shift_ready, o_de, o_B, o_coef_idx, o_blk_idx, o_comp
  );

  modport slave (
    input  i_de, i_B, i_ready,
    output o_shift_ready, o_de, o_B, o_coef_idx, o_blk_idx, o_comp
  );
endinterface

// File: rtl/mcu_block_sequencer_dc_predictor.sv
// Per-component DC predictors and the reconstruction adder.
// A same-cycle restart clear makes the sum start from zero.
module mcu_block_sequencer_dc_predictor #(
  parameter int AMPLITUDE_PRECISION = 16
) (
  input  logic                           i_sysclk,
  input  logic                           i_arst,
  input  logic                           i_clr_all,
  input  logic                           i_dc_clear,
  input  logic                           i_dc_en,
  input  logic [1:0]                     i_comp,
  input  logic [AMPLITUDE_PRECISION-1:0] i_diff,
  output logic [AMPLITUDE_PRECISION-1:0] o_sum
);
  logic [2:0][AMPLITUDE_PRECISION-1:0] r_pred;
  logic [AMPLITUDE_PRECISION-1:0]      w_base;

  always_comb begin
    w_base = '0;
    for (int k = 0; k < 3; k++)
      if (i_comp == k[1:0]) w_base = r_pred[k];
    if (i_dc_clear) w_base = '0;
  end

  assign o_sum = w_base + i_diff;

  always_ff @(posedge i_sysclk) begin
    if (i_arst || i_clr_all) begin
      r_pred <= '0;
    end else begin
      if (i_dc_clear) r_pred <= '0;
      for (int k = 0; k < 3; k++)
        if (i_dc_en && i_comp == k[1:0]) r_pred[k] <= o_sum;
    end
  end
endmodule

// File: rtl/mcu_block_sequencer.sv
// Walks coefficient/block/MCU counters over a JPEG scan, reconstructs DC values
// and tags each emitted coefficient with its position and component.
module mcu_block_sequencer
  import mcu_block_sequencer_pkg::*;
#(
  parameter int AMPLITUDE_PRECISION = 16,
  parameter int MCU_SIZE            = 64
) (
  input  logic        i_sysclk,
  input  logic        i_arst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [1:0]  i_samp_mode,
  input  logic [15:0] i_mcu_total,
  input  logic        i_dc_clear,
  mcu_block_sequencer_if.slave bus,
  output logic [1:0]  o_comp_sel,
  output logic        o_dc_next,
  output logic        o_busy,
  output logic        o_done
);
  state_e     r_state, w_state_nxt;
  samp_mode_e r_mode;
  logic [15:0] r_total, r_mcu;
  logic [5:0]  r_coef;
  logic [2:0]  r_blk;

  logic                           r_de, r_done;
  logic [AMPLITUDE_PRECISION-1:0] r_B;
  logic [5:0]                     r_coef_idx;
  logic [2:0]                     r_blk_idx;
  logic [1:0]                     r_comp;

  logic                           w_accept, w_emit, w_start, w_last;
  logic                           w_coef_wrap, w_blk_wrap;
  comp_e                          w_comp;
  logic [AMPLITUDE_PRECISION-1:0] w_sum;

  assign bus.o_shift_ready = (r_state == ST_RUN) & bus.i_ready;
  assign w_accept    = bus.i_de & bus.o_shift_ready;
  assign w_emit      = w_accept & ~i_abort;
  assign w_start     = i_start & (r_state == ST_IDLE) & ~i_abort;
  assign w_coef_wrap = (r_coef == 6'(MCU_SIZE - 1));
  assign w_blk_wrap  = (r_blk == blocks_per_mcu(r_mode) - 3'd1);
  assign w_last      = w_accept & w_coef_wrap & w_blk_wrap & (r_mcu == r_total - 16'd1);
  assign w_comp      = blk_comp(r_mode, r_blk);

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (i_start) w_state_nxt = (i_mcu_total != 16'd0) ? ST_RUN : ST_FINISH;
        ST_RUN:    if (w_last) w_state_nxt = ST_FINISH;
        ST_FINISH: w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_arst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      r_mode  <= SM_444;
      r_total <= '0;
      r_coef  <= '0;
      r_blk   <= '0;
      r_mcu   <= '0;
    end else if (i_abort) begin
      r_coef <= '0;
      r_blk  <= '0;
      r_mcu  <= '0;
    end else if (w_start) begin
      r_mode  <= samp_mode_e'(i_samp_mode);
      r_total <= i_mcu_total;
      r_coef  <= '0;
      r_blk   <= '0;
      r_mcu   <= '0;
    end else if (w_accept) begin
      if (w_coef_wrap) begin
        r_coef <= '0;
        if (w_blk_wrap) begin
          r_blk <= '0;
          r_mcu <= r_mcu + 16'd1;
        end else begin
          r_blk <= r_blk + 3'd1;
        end
      end else begin
        r_coef <= r_coef + 6'd1;
      end
    end
  end

  mcu_block_sequencer_dc_predictor #(
    .AMPLITUDE_PRECISION(AMPLITUDE_PRECISION)
  ) u_dc_predictor (
    .i_sysclk  (i_sysclk),
    .i_arst    (i_arst),
    .i_clr_all (w_start),
    .i_dc_clear(i_dc_clear),
    .i_dc_en   (w_emit & (r_coef == 6'd0)),
    .i_comp    (w_comp),
    .i_diff    (bus.i_B),
    .o_sum     (w_sum)
  );

  // Output stage; o_done lands the cycle after FINISH, i.e. one after the last o_de.
  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      r_de       <= 1'b0;
      r_done     <= 1'b0;
      r_B        <= '0;
      r_coef_idx <= '0;
      r_blk_idx  <= '0;
      r_comp     <= '0;
    end else begin
      r_de   <= w_emit;
      r_done <= (r_state == ST_FINISH) & ~i_abort;
      if (w_emit) begin
        r_B        <= (r_coef == 6'd0) ? w_sum : bus.i_B;
        r_coef_idx <= r_coef;
        r_blk_idx  <= r_blk;
        r_comp     <= w_comp;
      end
    end
  end

  assign bus.o_de       = r_de;
  assign bus.o_B        = r_B;
  assign bus.o_coef_idx = r_coef_idx;
  assign bus.o_blk_idx  = r_blk_idx;
  assign bus.o_comp     = r_comp;
  assign o_done         = r_done;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_comp_sel     = w_comp;
  assign o_dc_next      = (r_coef == 6'd0);
endmodule

// File: tb/tb_mcu_block_sequencer.sv
// Directed and randomized scans against a coefficient-sequence reference model.
module tb_mcu_block_sequencer;
  localparam int AP  = 16;
  localparam int MSZ = 64;
  localparam int T_PLAIN = 0, T_GRAY = 1, T_CLR = 2, T_STALL = 3, T_ABORT = 4, T_RAND = 5, T_RST = 6;

  logic        clk = 1'b0;
  logic        rst, start, abort, dcclr;
  logic [1:0]  smode;
  logic [15:0] total;
  logic [1:0]  comp_sel;
  logic        dc_next, busy, done;

  mcu_block_sequencer_if #(.AMPLITUDE_PRECISION(AP)) bus ();

  mcu_block_sequencer #(.AMPLITUDE_PRECISION(AP), .MCU_SIZE(MSZ)) dut (
    .i_sysclk(clk), .i_arst(rst), .i_start(start), .i_abort(abort),
    .i_samp_mode(smode), .i_mcu_total(total), .i_dc_clear(dcclr), .bus(bus),
    .o_comp_sel(comp_sel), .o_dc_next(dc_next), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Model: position n in the scan's coefficient sequence, plus predictors.
  bit          m_run, m_fin, m_done, pend;
  int          n, m_mode, m_total, m_nblk;
  logic [15:0] pred [3];
  logic [15:0] p_b;
  int          p_idx, p_blk, p_comp;
  int          de_cnt;
  logic [15:0] dc_obs [$];

  function automatic int nblk_of(input int m);
    case (m)
      0: return 3;
      1: return 4;
      2: return 6;
      default: return 1;
    endcase
  endfunction

  function automatic int comp_of(input int m, input int b);
    case (m)
      0: return b;
      1: return (b < 2) ? 0 : b - 1;
      2: return (b < 4) ? 0 : b - 3;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_fin = 0; m_done = 0; pend = 0; n = 0;
    m_mode = 0; m_total = 0; m_nblk = 3;
    for (int k = 0; k < 3; k++) pred[k] = '0;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; abort = 0; dcclr = 0; bus.i_de = 0; bus.i_B = '0; bus.i_ready = 1;
    smode = 2'd0; total = 16'd0;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_o_de", 32'(bus.o_de), 32'(0));
    chk("rst_o_B", 32'(bus.o_B), 32'(0));
    chk("rst_coef_idx", 32'(bus.o_coef_idx), 32'(0));
    chk("rst_blk_idx", 32'(bus.o_blk_idx), 32'(0));
    chk("rst_comp", 32'(bus.o_comp), 32'(0));
    chk("rst_comp_sel", 32'(comp_sel), 32'(0));
    chk("rst_dc_next", 32'(dc_next), 32'(1));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_shift_ready", 32'(bus.o_shift_ready), 32'(0));
    model_reset();
  endtask

  task automatic step(input bit st, input bit ab, input bit de, input logic [15:0] b,
                      input bit clr, input bit rdy, input int mode, input int tot);
    bit exp_rdy, acc;
    int c, bk, cp;
    start = st; abort = ab; bus.i_de = de; bus.i_B = b; dcclr = clr; bus.i_ready = rdy;
    smode = mode[1:0]; total = tot[15:0];
    @(negedge clk);
    exp_rdy = m_run && rdy;
    chk("shift_ready", 32'(bus.o_shift_ready), 32'(exp_rdy));
    chk("o_de", 32'(bus.o_de), 32'(pend));
    if (pend) begin
      chk("o_B", 32'(bus.o_B), 32'(p_b));
      chk("o_coef_idx", 32'(bus.o_coef_idx), 32'(p_idx));
      chk("o_blk_idx", 32'(bus.o_blk_idx), 32'(p_blk));
      chk("o_comp", 32'(bus.o_comp), 32'(p_comp));
    end
    if (bus.o_de === 1'b1) begin
      de_cnt++;
      if (bus.o_coef_idx == 6'd0) dc_obs.push_back(bus.o_B);
    end
    chk("o_done", 32'(done), 32'(m_done));
    chk("o_busy", 32'(busy), 32'(m_run | m_fin));
    chk("dc_next", 32'(dc_next), 32'((n % MSZ) == 0));
    chk("comp_sel", 32'(comp_sel), 32'(comp_of(m_mode, (n / MSZ) % m_nblk)));
    acc    = de && exp_rdy;
    m_done = m_fin && !ab;
    pend   = 0;
    if (clr) for (int k = 0; k < 3; k++) pred[k] = '0;
    if (ab) begin
      m_run = 0; m_fin = 0; n = 0;
    end else if (!m_run && !m_fin) begin
      if (st) begin
        m_mode = mode; m_total = tot; m_nblk = nblk_of(mode); n = 0;
        for (int k = 0; k < 3; k++) pred[k] = '0;
        if (tot == 0) m_fin = 1; else m_run = 1;
      end
    end else if (m_fin) begin
      m_fin = 0;
    end else if (acc) begin
      c = n % MSZ; bk = (n / MSZ) % m_nblk; cp = comp_of(m_mode, bk);
      if (c == 0) begin
        p_b = pred[cp] + b;
        pred[cp] = p_b;
      end else begin
        p_b = b;
      end
      p_idx = c; p_blk = bk; p_comp = cp; pend = 1; n++;
      if (n == m_total * m_nblk * MSZ) begin
        m_run = 0; m_fin = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic stim(input int t, input int cyc, output bit st, output bit ab, output bit de,
                      output logic [15:0] b, output bit clr, output bit rdy);
    st = 0; ab = 0; de = 1; b = 16'($urandom); clr = 0; rdy = 1;
    case (t)
      T_GRAY: begin
        if (n == 0)  b = 16'd5;
        if (n == 64) b = 16'hFFFD;
      end
      T_CLR: begin
        if (n == 64)  b = 16'd20;
        if (n == 256) begin b = 16'd7; clr = 1; end
        if (n == 448) b = 16'd3;
      end
      T_STALL: rdy = !(cyc >= 100 && cyc < 110);
      T_ABORT: ab = (n == 100);
      T_RAND: begin
        de  = ($urandom_range(0, 9) < 7);
        rdy = ($urandom_range(0, 9) < 8);
        clr = ($urandom_range(0, 49) == 0);
        st  = ($urandom_range(0, 19) == 0);
      end
      default: ;
    endcase
  endtask

  task automatic scan(input int t, input int mode, input int tot);
    int cyc;
    bit st, ab, de, clr, rdy;
    logic [15:0] b;
    de_cnt = 0;
    dc_obs.delete();
    step(1, 0, 0, 16'd0, 0, 1, mode, tot);
    cyc = 0;
    while ((m_run || m_fin) && cyc < 5000) begin
      stim(t, cyc, st, ab, de, b, clr, rdy);
      // Mode/total wiggle outside the start cycle; the DUT must hold its latched copy.
      step(st, ab, de, b, clr, rdy, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      cyc++;
      if (t == T_RST && cyc == 50) break;
    end
    chk("scan_cycle_bound", 32'(cyc < 5000), 32'(1));
    if (t != T_RST)
      for (int i = 0; i < 2; i++) step(0, 0, 1, 16'($urandom), 0, 1, 0, 0);
  endtask

  initial begin
    do_reset();

    scan(T_PLAIN, 2, 1);
    chk("420_de_count", 32'(de_cnt), 32'(384));
    chk("420_dc_count", 32'(dc_obs.size()), 32'(6));

    scan(T_GRAY, 3, 2);
    chk("gray_dc_count", 32'(dc_obs.size()), 32'(2));
    if (dc_obs.size() == 2) begin
      chk("gray_dc0", 32'(dc_obs[0]), 32'(5));
      chk("gray_dc1", 32'(dc_obs[1]), 32'(2));
    end

    scan(T_CLR, 0, 3);
    chk("clr_dc_count", 32'(dc_obs.size()), 32'(9));
    if (dc_obs.size() == 9) begin
      chk("clr_cb_mcu0", 32'(dc_obs[1]), 32'(20));
      chk("clr_cb_mcu1", 32'(dc_obs[4]), 32'(7));
      chk("clr_cb_mcu2", 32'(dc_obs[7]), 32'(10));
    end

    scan(T_STALL, 0, 1);
    chk("stall_de_count", 32'(de_cnt), 32'(192));

    scan(T_PLAIN, 1, 0);
    chk("zero_de_count", 32'(de_cnt), 32'(0));

    scan(T_ABORT, 1, 2);
    chk("abort_de_count", 32'(de_cnt), 32'(100));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'($urandom), 0, 1, 0, 0);
    scan(T_PLAIN, 1, 1);
    chk("restart_de_count", 32'(de_cnt), 32'(256));

    for (int r = 0; r < 4; r++)
      scan(T_RAND, int'($urandom_range(0, 3)), int'($urandom_range(1, 2)));

    scan(T_RST, 2, 2);
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'($urandom), 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
